// File: rtl/yutorina_exc_ctrl.sv
// Exception, interrupt and SPR controller for the Yutorina pipeline.
// Arbitrates MEM-stage events, keeps a nesting stack of return state and drives flush/redirect.
module yutorina_exc_ctrl #(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned INT_N       = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned SPR_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              d_busy,
  output logic              stall,
  input  logic              eret,
  input  logic              mem_valid,
  input  logic [3:0]        exc_code,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [INT_N-1:0]  irq,
  input  logic              spr_we,
  input  logic [SPR_AW-1:0] spr_waddr,
  input  logic [DATA_W-1:0] spr_wdata,
  input  logic [SPR_AW-1:0] spr_raddr,
  output logic [DATA_W-1:0] spr_rdata,
  output logic              mode,
  output logic              flush,
  output logic              id_flush,
  output logic [ADDR_W-1:0] new_pc
);

  localparam int unsigned PEND_W  = INT_N + 1;
  localparam int unsigned IDX_W   = (PEND_W > 1) ? $clog2(PEND_W) : 1;
  localparam int unsigned HI_W    = CNT_W - DATA_W;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] CODE_INT  = 4'h1;
  localparam logic [3:0] CODE_PRIV = 4'h9;
  localparam logic [3:0] CODE_ERET = 4'hE;
  localparam logic [3:0] CODE_DBL  = 4'hF;

  localparam logic [SPR_AW-1:0] SPR_PC     = SPR_AW'(0);
  localparam logic [SPR_AW-1:0] SPR_EPC    = SPR_AW'(1);
  localparam logic [SPR_AW-1:0] SPR_CNT_L  = SPR_AW'(2);
  localparam logic [SPR_AW-1:0] SPR_CNT_H  = SPR_AW'(3);
  localparam logic [SPR_AW-1:0] SPR_VECTOR = SPR_AW'(4);
  localparam logic [SPR_AW-1:0] SPR_MODE   = SPR_AW'(5);
  localparam logic [SPR_AW-1:0] SPR_IMASK  = SPR_AW'(6);
  localparam logic [SPR_AW-1:0] SPR_IPEND  = SPR_AW'(7);
  localparam logic [SPR_AW-1:0] SPR_CAUSE  = SPR_AW'(8);
  localparam logic [SPR_AW-1:0] SPR_CMP_L  = SPR_AW'(9);
  localparam logic [SPR_AW-1:0] SPR_CMP_H  = SPR_AW'(10);
  localparam logic [SPR_AW-1:0] SPR_DEPTH  = SPR_AW'(11);

  logic               mode_q, mode_d;
  logic               ie_q, ie_d;
  logic [ADDR_W-1:0]  vector_q, vector_d;
  logic [PEND_W-1:0]  imask_q, imask_d;
  logic [PEND_W-1:0]  ipend_q, ipend_d;
  logic [DATA_W-1:0]  cause_q, cause_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HI_W-1:0]    shadow_q, shadow_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               flush_q, flush_d;
  logic               id_flush_q, id_flush_d;
  logic [ADDR_W-1:0]  new_pc_q, new_pc_d;

  logic [ADDR_W-1:0]  stk_pc_q   [STACK_DEPTH];
  logic [ADDR_W-1:0]  stk_pc_d   [STACK_DEPTH];
  logic               stk_mode_q [STACK_DEPTH];
  logic               stk_mode_d [STACK_DEPTH];
  logic               stk_ie_q   [STACK_DEPTH];
  logic               stk_ie_d   [STACK_DEPTH];

  logic [PEND_W-1:0]  pend_set;
  logic [PEND_W-1:0]  pend_en;
  logic [IDX_W-1:0]   int_idx;
  logic [SIDX_W-1:0]  tos_idx;
  logic [SIDX_W-1:0]  push_idx;
  logic               ev_en;
  logic               take_exc;
  logic               take_int;
  logic               priv_wr;
  logic               kern_wr;
  logic               enter;
  logic [3:0]         enter_code;
  logic [IDX_W-1:0]   enter_idx;

  assign stall    = i_busy | d_busy;
  assign mode     = mode_q;
  assign flush    = flush_q;
  assign id_flush = id_flush_q;
  assign new_pc   = new_pc_q;

  // Pending sources: level interrupts plus the compare timer in the top bit.
  assign pend_set = {cnt_q == cmp_q, irq};
  assign pend_en  = ipend_q & imask_q;
  assign tos_idx  = SIDX_W'(depth_q - DEPTH_W'(1));
  assign push_idx = SIDX_W'(depth_q);

  // The cycle following a redirect is blind so a flushed exception is not taken twice.
  assign ev_en    = ~stall & ~flush_q;
  assign take_exc = mem_valid & (exc_code != 4'h0);
  assign take_int = mem_valid & ie_q & (|pend_en);
  assign priv_wr  = mem_valid & spr_we & mode_q;
  assign kern_wr  = mem_valid & spr_we & ~mode_q;

  // Lowest-numbered pending-and-enabled source.
  always_comb begin
    int_idx = '0;
    for (int i = int'(PEND_W) - 1; i >= 0; i--) begin
      if (pend_en[i]) int_idx = IDX_W'(i);
    end
  end

  // SPR read mux.
  always_comb begin
    spr_rdata = '0;
    case (spr_raddr)
      SPR_PC:     spr_rdata = DATA_W'({mem_pc, 2'b00});
      SPR_EPC:    if (depth_q != '0) spr_rdata = DATA_W'({stk_pc_q[tos_idx], 2'b00});
      SPR_CNT_L:  spr_rdata = cnt_q[DATA_W-1:0];
      SPR_CNT_H:  spr_rdata = DATA_W'(shadow_q);
      SPR_VECTOR: spr_rdata = DATA_W'(vector_q);
      SPR_MODE:   spr_rdata = DATA_W'({ie_q, mode_q});
      SPR_IMASK:  spr_rdata = DATA_W'(imask_q);
      SPR_IPEND:  spr_rdata = DATA_W'(ipend_q);
      SPR_CAUSE:  spr_rdata = cause_q;
      SPR_CMP_L:  spr_rdata = cmp_q[DATA_W-1:0];
      SPR_CMP_H:  spr_rdata = DATA_W'(cmp_q[CNT_W-1:DATA_W]);
      SPR_DEPTH:  spr_rdata = DATA_W'(depth_q);
      default:    spr_rdata = '0;
    endcase
  end

  // Event arbitration and next-state for every architectural register.
  always_comb begin
    mode_d     = mode_q;
    ie_d       = ie_q;
    vector_d   = vector_q;
    imask_d    = imask_q;
    cause_d    = cause_q;
    cmp_d      = cmp_q;
    depth_d    = depth_q;
    stk_pc_d   = stk_pc_q;
    stk_mode_d = stk_mode_q;
    stk_ie_d   = stk_ie_q;
    flush_d    = 1'b0;
    id_flush_d = 1'b0;
    new_pc_d   = new_pc_q;
    shadow_d   = (spr_raddr == SPR_CNT_L) ? cnt_q[CNT_W-1:DATA_W] : shadow_q;
    cnt_d      = cnt_q + CNT_W'(1);
    ipend_d    = ipend_q | pend_set;
    enter      = 1'b0;
    enter_code = 4'h0;
    enter_idx  = '0;

    if (ev_en) begin
      if (take_exc) begin
        enter      = 1'b1;
        enter_code = exc_code;
      end else if (take_int) begin
        enter      = 1'b1;
        enter_code = CODE_INT;
        enter_idx  = int_idx;
      end else if (priv_wr) begin
        enter      = 1'b1;
        enter_code = CODE_PRIV;
      end else if (eret) begin
        if (depth_q == '0) begin
          enter      = 1'b1;
          enter_code = CODE_ERET;
        end else begin
          new_pc_d   = stk_pc_q[tos_idx];
          mode_d     = stk_mode_q[tos_idx];
          ie_d       = stk_ie_q[tos_idx];
          depth_d    = depth_q - DEPTH_W'(1);
          flush_d    = 1'b1;
          id_flush_d = 1'b1;
        end
      end else if (kern_wr) begin
        flush_d  = 1'b1;
        new_pc_d = mem_pc + ADDR_W'(1);
        case (spr_waddr)
          SPR_CNT_L:  cnt_d = {cnt_q[CNT_W-1:DATA_W], spr_wdata};
          SPR_CNT_H:  cnt_d = {HI_W'(spr_wdata), cnt_q[DATA_W-1:0]};
          SPR_VECTOR: vector_d = ADDR_W'(spr_wdata);
          SPR_MODE: begin
            mode_d = spr_wdata[0];
            ie_d   = spr_wdata[1];
          end
          SPR_IMASK:  imask_d = PEND_W'(spr_wdata);
          SPR_IPEND:  ipend_d = (ipend_q & ~PEND_W'(spr_wdata)) | pend_set;
          SPR_CAUSE:  cause_d = spr_wdata;
          SPR_CMP_L:  cmp_d = {cmp_q[CNT_W-1:DATA_W], spr_wdata};
          SPR_CMP_H:  cmp_d = {HI_W'(spr_wdata), cmp_q[DATA_W-1:0]};
          default: ;
        endcase
      end
    end

    // A full stack still redirects, but reports a double fault instead of pushing.
    if (enter) begin
      mode_d   = 1'b0;
      ie_d     = 1'b0;
      new_pc_d = vector_q;
      flush_d  = 1'b1;
      if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
        cause_d = DATA_W'({enter_idx, CODE_DBL});
      end else begin
        stk_pc_d[push_idx]   = mem_pc;
        stk_mode_d[push_idx] = mode_q;
        stk_ie_d[push_idx]   = ie_q;
        depth_d              = depth_q + DEPTH_W'(1);
        cause_d              = DATA_W'({enter_idx, enter_code});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      ie_q       <= 1'b0;
      vector_q   <= '0;
      imask_q    <= '0;
      ipend_q    <= '0;
      cause_q    <= '0;
      cmp_q      <= '1;
      cnt_q      <= '0;
      shadow_q   <= '0;
      depth_q    <= '0;
      flush_q    <= 1'b0;
      id_flush_q <= 1'b0;
      new_pc_q   <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stk_pc_q[i]   <= '0;
        stk_mode_q[i] <= 1'b0;
        stk_ie_q[i]   <= 1'b0;
      end
    end else begin
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      vector_q   <= vector_d;
      imask_q    <= imask_d;
      ipend_q    <= ipend_d;
      cause_q    <= cause_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      depth_q    <= depth_d;
      flush_q    <= flush_d;
      id_flush_q <= id_flush_d;
      new_pc_q   <= new_pc_d;
      stk_pc_q   <= stk_pc_d;
      stk_mode_q <= stk_mode_d;
      stk_ie_q   <= stk_ie_d;
    end
  end

endmodule

// File: tb/tb_yutorina_exc_ctrl.sv
// Bench for yutorina_exc_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based architectural model.
module tb_yutorina_exc_ctrl;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned INT_N  = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_busy, d_busy, stall;
  logic              eret, mem_valid;
  logic [3:0]        exc_code;
  logic [ADDR_W-1:0] mem_pc;
  logic [INT_N-1:0]  irq;
  logic              spr_we;
  logic [4:0]        spr_waddr, spr_raddr;
  logic [DATA_W-1:0] spr_wdata, spr_rdata;
  logic              mode, flush, id_flush;
  logic [ADDR_W-1:0] new_pc;

  yutorina_exc_ctrl dut (
    .clk(clk), .rst(rst), .i_busy(i_busy), .d_busy(d_busy), .stall(stall),
    .eret(eret), .mem_valid(mem_valid), .exc_code(exc_code), .mem_pc(mem_pc),
    .irq(irq), .spr_we(spr_we), .spr_waddr(spr_waddr), .spr_wdata(spr_wdata),
    .spr_raddr(spr_raddr), .spr_rdata(spr_rdata), .mode(mode), .flush(flush),
    .id_flush(id_flush), .new_pc(new_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Architectural model: the stack is a queue of saved frames.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              md;
    logic              ie;
  } frame_t;

  frame_t            m_stack[$];
  logic              m_valid = 1'b0;
  logic              m_mode, m_ie, m_flush, m_idflush;
  logic [ADDR_W-1:0] m_newpc, m_vector;
  logic [8:0]        m_imask, m_ipend;
  logic [31:0]       m_cause, m_shadow;
  logic [63:0]       m_cmp, m_cnt;
  logic [31:0]       rd_sample;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:  return {mem_pc, 2'b00};
      5'd1:  return (m_stack.size() == 0) ? 32'd0 : {m_stack[m_stack.size()-1].pc, 2'b00};
      5'd2:  return m_cnt[31:0];
      5'd3:  return m_shadow;
      5'd4:  return 32'(m_vector);
      5'd5:  return {30'd0, m_ie, m_mode};
      5'd6:  return 32'(m_imask);
      5'd7:  return 32'(m_ipend);
      5'd8:  return m_cause;
      5'd9:  return m_cmp[31:0];
      5'd10: return m_cmp[63:32];
      5'd11: return 32'(m_stack.size());
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_enter(input logic [3:0] code, input int idx);
    frame_t f;
    if (m_stack.size() == DEPTH) begin
      m_cause = {28'(idx), 4'hF};
    end else begin
      f.pc = mem_pc;
      f.md = m_mode;
      f.ie = m_ie;
      m_stack.push_back(f);
      m_cause = {28'(idx), code};
    end
    m_mode  = 1'b0;
    m_ie    = 1'b0;
    m_newpc = m_vector;
    m_flush = 1'b1;
  endtask

  task automatic model_step();
    logic [8:0]  setv, pe, nipend;
    logic [63:0] ncnt;
    logic        was_flush;
    int          idx;
    frame_t      f;
    if (rst) begin
      m_mode = 0; m_ie = 0; m_flush = 0; m_idflush = 0; m_newpc = '0; m_vector = '0;
      m_imask = '0; m_ipend = '0; m_cause = '0; m_shadow = '0;
      m_cmp = '1; m_cnt = '0;
      m_stack.delete();
      m_valid = 1'b1;
      return;
    end
    setv   = {m_cnt == m_cmp, irq};
    pe     = m_ipend & m_imask;
    idx    = 0;
    for (int i = 0; i <= int'(INT_N); i++) begin
      if (pe[i]) begin
        idx = i;
        break;
      end
    end
    nipend = m_ipend | setv;
    ncnt   = m_cnt + 64'd1;
    if (spr_raddr == 5'd2) m_shadow = m_cnt[63:32];
    was_flush = m_flush;
    m_flush   = 1'b0;
    m_idflush = 1'b0;
    if (!(i_busy || d_busy) && !was_flush) begin
      if (mem_valid && exc_code != 4'd0) m_enter(exc_code, 0);
      else if (mem_valid && m_ie && pe != 9'd0) m_enter(4'h1, idx);
      else if (mem_valid && spr_we && m_mode) m_enter(4'h9, 0);
      else if (eret) begin
        if (m_stack.size() == 0) m_enter(4'hE, 0);
        else begin
          f = m_stack.pop_back();
          m_newpc = f.pc; m_mode = f.md; m_ie = f.ie;
          m_flush = 1'b1; m_idflush = 1'b1;
        end
      end else if (mem_valid && spr_we) begin
        m_flush = 1'b1;
        m_newpc = mem_pc + 30'd1;
        case (spr_waddr)
          5'd2:  ncnt = {m_cnt[63:32], spr_wdata};
          5'd3:  ncnt = {spr_wdata, m_cnt[31:0]};
          5'd4:  m_vector = spr_wdata[29:0];
          5'd5:  begin m_mode = spr_wdata[0]; m_ie = spr_wdata[1]; end
          5'd6:  m_imask = spr_wdata[8:0];
          5'd7:  nipend = (m_ipend & ~spr_wdata[8:0]) | setv;
          5'd8:  m_cause = spr_wdata;
          5'd9:  m_cmp[31:0] = spr_wdata;
          5'd10: m_cmp[63:32] = spr_wdata;
          default: ;
        endcase
      end
    end
    m_ipend = nipend;
    m_cnt   = ncnt;
  endtask

  // One clock: combinational outputs on the falling edge, registered ones just after the rise.
  task automatic tick();
    @(negedge clk);
    rd_sample = spr_rdata;
    if (m_valid) begin
      chk("stall", 64'(stall), 64'(i_busy | d_busy));
      chk("rdata", 64'(spr_rdata), 64'(m_read(spr_raddr)));
    end
    @(posedge clk);
    model_step();
    #1;
    chk("flush", 64'(flush), 64'(m_flush));
    chk("id_flush", 64'(id_flush), 64'(m_idflush));
    chk("new_pc", 64'(new_pc), 64'(m_newpc));
    chk("mode", 64'(mode), 64'(m_mode));
  endtask

  task automatic idle();
    i_busy = 0; d_busy = 0; eret = 0; mem_valid = 0; exc_code = '0;
    irq = '0; spr_we = 0; spr_waddr = '0; spr_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic kwrite(input logic [4:0] a, input logic [31:0] d);
    mem_valid = 1; spr_we = 1; spr_waddr = a; spr_wdata = d;
    tick();
    idle();
    tick();
  endtask

  task automatic rd_expect(input string tag, input logic [4:0] a, input logic [31:0] e);
    spr_raddr = a;
    tick();
    chk(tag, 64'(rd_sample), 64'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst = 1'b0; mem_pc = '0; spr_raddr = '0;
    idle();

    // Reset values and basic exception entry.
    do_reset();
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_newpc", 64'(new_pc), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    rd_expect("rst_cntl", 5'd2, 32'd0);
    rd_expect("rst_cmpl", 5'd9, 32'hFFFF_FFFF);
    rd_expect("rst_depth", 5'd11, 32'd0);
    kwrite(5'd4, 32'h100);
    mem_valid = 1; exc_code = 4'd3; mem_pc = 30'h20;
    tick();
    chk("exc_flush", 64'(flush), 64'd1);
    chk("exc_newpc", 64'(new_pc), 64'h100);
    chk("exc_mode", 64'(mode), 64'd0);
    idle();
    tick();
    chk("exc_flush_drop", 64'(flush), 64'd0);
    rd_expect("exc_epc", 5'd1, 32'h80);
    rd_expect("exc_cause", 5'd8, 32'd3);
    rd_expect("exc_depth", 5'd11, 32'd1);

    // Interrupt entry and W1C of its pending bit.
    do_reset();
    kwrite(5'd6, 32'h04);
    kwrite(5'd5, 32'h02);
    irq = 8'h04;
    tick();
    irq = '0; mem_valid = 1;
    tick();
    chk("int_flush", 64'(flush), 64'd1);
    idle();
    tick();
    rd_expect("int_cause", 5'd8, 32'h21);
    kwrite(5'd7, 32'h04);
    rd_expect("int_w1c", 5'd7, 32'd0);

    // Nesting to overflow, then unwinding past empty.
    do_reset();
    kwrite(5'd4, 32'h40);
    for (int k = 0; k <= int'(DEPTH); k++) begin
      kwrite(5'd5, 32'h02);
      mem_valid = 1; exc_code = 4'd5; mem_pc = 30'(32'h100 + k);
      tick();
      idle();
      tick();
    end
    rd_expect("dbl_cause", 5'd8, 32'hF);
    rd_expect("dbl_depth", 5'd11, 32'd4);
    for (int k = 0; k < int'(DEPTH); k++) begin
      eret = 1;
      tick();
      chk("eret_pc", 64'(new_pc), 64'(32'h103 - k));
      chk("eret_idf", 64'(id_flush), 64'd1);
      idle();
      tick();
    end
    rd_expect("eret_depth", 5'd11, 32'd0);
    eret = 1;
    tick();
    chk("eret0_idf", 64'(id_flush), 64'd0);
    idle();
    tick();
    rd_expect("eret0_cause", 5'd8, 32'hE);

    // Compare timer and coherent counter read.
    do_reset();
    kwrite(5'd10, 32'd0);
    kwrite(5'd9, 32'd50);
    spr_raddr = 5'd7;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (rd_sample[8]) begin
        found = 1'b1;
        break;
      end
    end
    chk("tmr_found", 64'(found), 64'd1);
    rd_expect("tmr_cnt", 5'd2, 32'd52);
    kwrite(5'd3, 32'd7);
    kwrite(5'd2, 32'hFFFF_FFFE);
    rd_expect("cnt_lo", 5'd2, 32'hFFFF_FFFF);
    rd_expect("cnt_hi", 5'd3, 32'd7);

    // Exception beats ERET; stall defers the event.
    do_reset();
    kwrite(5'd4, 32'h80);
    mem_valid = 1; exc_code = 4'd2; eret = 1; mem_pc = 30'h33;
    tick();
    chk("pri_flush", 64'(flush), 64'd1);
    chk("pri_idf", 64'(id_flush), 64'd0);
    chk("pri_newpc", 64'(new_pc), 64'h80);
    idle();
    tick();
    rd_expect("pri_depth", 5'd11, 32'd1);
    mem_valid = 1; exc_code = 4'd6; i_busy = 1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stall_noflush", 64'(flush), 64'd0);
    end
    i_busy = 0;
    tick();
    chk("stall_release", 64'(flush), 64'd1);
    idle();
    tick();
    rd_expect("stall_depth", 5'd11, 32'd2);

    // User-mode SPR write is privileged.
    do_reset();
    kwrite(5'd5, 32'h01);
    mem_valid = 1; spr_we = 1; spr_waddr = 5'd4; spr_wdata = 32'h55;
    tick();
    chk("priv_flush", 64'(flush), 64'd1);
    idle();
    tick();
    rd_expect("priv_cause", 5'd8, 32'h9);
    rd_expect("priv_vector", 5'd4, 32'd0);
    rd_expect("priv_mode", 5'd5, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 599) == 0);
      i_busy    = ($urandom_range(0, 3) == 0);
      d_busy    = ($urandom_range(0, 5) == 0);
      eret      = ($urandom_range(0, 7) == 0);
      mem_valid = ($urandom_range(0, 1) == 0);
      exc_code  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      irq       = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'd0;
      mem_pc    = 30'($urandom);
      spr_we    = ($urandom_range(0, 3) == 0);
      spr_waddr = 5'($urandom_range(0, 15));
      spr_wdata = $urandom;
      spr_raddr = 5'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
